// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX FIFO write port.
// Forwards whole frames only, truncates over-long frames and holds off new grants while the FIFO is full.
module mac_tx_arbiter #(
    parameter int         NUM_PORTS       = 2,
    parameter int         MAX_FRAME_LEN   = 1518,
    parameter logic [3:0] FIFO_HOLD_LEVEL = 4'd12
) (
    input  logic                     tx_fifo_aclk,
    input  logic                     tx_fifo_reset,
    input  logic [8*NUM_PORTS-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS-1:0]     s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]     s_axis_tlast,
    output logic [NUM_PORTS-1:0]     s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic [3:0]               tx_fifo_status,
    output logic [NUM_PORTS-1:0]     grant,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_truncated
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(MAX_FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_last;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic                   r_frame_done;
    logic                   r_frame_trunc;

    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_pick_vld;
    logic [NUM_PORTS-1:0]   w_pick_oh;
    logic [7:0]             w_own_data;
    logic                   w_own_valid;
    logic                   w_own_last;
    logic                   w_force_last;
    logic                   w_arb_go;
    logic                   w_m_beat;
    logic                   w_s_beat;

    // Owner-side mux: the registered owner index selects the source lane.
    always_comb begin
        w_own_data  = '0;
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_data  = s_axis_tdata[8*i +: 8];
                w_own_valid = s_axis_tvalid[i];
                w_own_last  = s_axis_tlast[i];
            end
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        w_pick     = r_last;
        w_pick_vld = 1'b0;
        w_idx      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = IDX_W'((int'(r_last) + k) % NUM_PORTS);
            if (!w_pick_vld && s_axis_tvalid[w_idx]) begin
                w_pick     = w_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_pick_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_pick_oh[i] = (w_pick == IDX_W'(i));
        end
    end

    assign w_force_last = (r_beat_cnt == CNT_FORCE);
    assign w_arb_go     = (r_state == ST_IDLE) && w_pick_vld && (tx_fifo_status < FIFO_HOLD_LEVEL);
    assign w_m_beat     = (r_state == ST_PASS) && w_own_valid && m_axis_tready;
    assign w_s_beat     = (r_state == ST_DROP) && w_own_valid;

    always_ff @(posedge tx_fifo_aclk or posedge tx_fifo_reset) begin
        if (tx_fifo_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_go) begin
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                // A natural tlast wins over the forced one on the final allowed beat.
                if (w_m_beat) begin
                    if (w_own_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_force_last) begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_s_beat && w_own_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_PASS: begin
                m_axis_tdata  = w_own_data;
                m_axis_tvalid = w_own_valid;
                m_axis_tlast  = w_own_last | w_force_last;
                s_axis_tready = r_grant & {NUM_PORTS{m_axis_tready}};
            end
            ST_DROP: begin
                s_axis_tready = r_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge tx_fifo_aclk or posedge tx_fifo_reset) begin
        if (tx_fifo_reset) begin
            r_grant       <= '0;
            r_owner       <= '0;
            r_last        <= LAST_RST;
            r_beat_cnt    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_trunc <= 1'b0;
        end else begin
            r_frame_done  <= (w_m_beat || w_s_beat) && w_own_last;
            r_frame_trunc <= w_m_beat && !w_own_last && w_force_last;
            if (w_arb_go) begin
                r_grant    <= w_pick_oh;
                r_owner    <= w_pick;
                r_last     <= w_pick;
                r_beat_cnt <= '0;
            end else if (w_state_nxt == ST_IDLE) begin
                r_grant <= '0;
            end
            if (w_m_beat && (r_beat_cnt != CNT_MAX)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign grant           = r_grant;
    assign busy            = (r_state != ST_IDLE);
    assign frame_done      = r_frame_done;
    assign frame_truncated = r_frame_trunc;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: drivers push expected beats per port,
// a monitor pops and compares every accepted m_axis beat.
module tb_mac_tx_arbiter;

    localparam int NP  = 2;
    localparam int MFL = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*NP-1:0] s_tdata;
    logic [NP-1:0]  s_tvalid;
    logic [NP-1:0]  s_tlast;
    logic [NP-1:0]  s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tready;
    logic [3:0]     status;
    logic [NP-1:0]  grant;
    logic           busy;
    logic           frame_done;
    logic           frame_truncated;

    logic [7:0]     v_data  [NP];
    logic           v_valid [NP];
    logic           v_last  [NP];

    logic [8:0]     q0[$];
    logic [8:0]     q1[$];
    int             q_owner[$];

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    int n_trunc = 0;
    int mbeats = 0;
    bit rdy_rand = 1'b0;
    bit abort = 1'b0;
    bit hung = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < NP; i++) begin
            s_tdata[8*i +: 8] = v_data[i];
            s_tvalid[i]       = v_valid[i];
            s_tlast[i]        = v_last[i];
        end
    end

    mac_tx_arbiter #(
        .NUM_PORTS      (NP),
        .MAX_FRAME_LEN  (MFL),
        .FIFO_HOLD_LEVEL(4'd12)
    ) dut (
        .tx_fifo_aclk   (clk),
        .tx_fifo_reset  (rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .tx_fifo_status (status),
        .grant          (grant),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_truncated(frame_truncated)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int p, input int len, input logic [7:0] base);
        logic [8:0] b;
        for (int i = 0; i < len && i < MFL; i++) begin
            b = {((i == len - 1) || (i == MFL - 1)), 8'(base + i)};
            if (p == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    // One frame on port p; gap is the percentage chance of idle cycles before each beat.
    task automatic send_frame(input int p, input int len, input logic [7:0] base, input int gap);
        bit hs;
        int budget;
        if (hung) return;
        push_exp(p, len, base);
        for (int i = 0; i < len; i++) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                v_valid[p] = 1'b0;
                v_last[p]  = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            v_valid[p] = 1'b1;
            v_data[p]  = 8'(base + i);
            v_last[p]  = (i == len - 1);
            hs = 1'b0;
            budget = 0;
            while (!hs) begin
                @(negedge clk);
                hs = s_tready[p];
                tick();
                budget++;
                if (abort || (!hs && budget > 2000)) begin
                    if (!abort) begin
                        n_total++;
                        hung = 1'b1;
                        $display("FAIL handshake_timeout port %0d beat %0d: no tready after %0d cycles, required one", p, i, budget);
                    end
                    v_valid[p] = 1'b0;
                    v_last[p]  = 1'b0;
                    return;
                end
            end
        end
        v_valid[p] = 1'b0;
        v_last[p]  = 1'b0;
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        int own;
        bit prev_end;
        bit in_frame;
        prev_end = 1'b0;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_end = 1'b0;
                in_frame = 1'b0;
            end else begin
                if (prev_end) begin
                    chk("idle_gap_busy", busy, 0);
                    chk("idle_gap_grant", grant, 0);
                end
                prev_end = 1'b0;
                if (frame_done) n_done++;
                if (frame_truncated) n_trunc++;
                if (m_tvalid && m_tready) begin
                    mbeats++;
                    chk("grant_onehot", $onehot(grant), 1);
                    own = grant[1] ? 1 : 0;
                    if (!in_frame && q_owner.size() > 0) chk("frame_owner", own, q_owner.pop_front());
                    in_frame = !m_tlast;
                    if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
                        n_total++;
                        $display("FAIL extra_beat port %0d: got data %0h, required no beat", own, m_tdata);
                    end else begin
                        e = (own == 0) ? q0.pop_front() : q1.pop_front();
                        chk("beat_data", m_tdata, e[7:0]);
                        chk("beat_last", m_tlast, e[8]);
                    end
                    prev_end = m_tlast && s_tlast[own];
                end
            end
        end
    endtask

    task automatic check_end(input string nm, input int d0, input int dd, input int t0, input int dt);
        repeat (3) tick();
        chk({nm, "_done"}, n_done - d0, dd);
        chk({nm, "_trunc"}, n_trunc - t0, dt);
        chk({nm, "_q0_left"}, q0.size(), 0);
        chk({nm, "_q1_left"}, q1.size(), 0);
    endtask

    initial begin
        int d0, t0, mb0;
        time ts, te;
        bit reached;
        for (int i = 0; i < NP; i++) begin
            v_data[i]  = '0;
            v_valid[i] = 1'b0;
            v_last[i]  = 1'b0;
        end
        m_tready = 1'b1;
        status   = 4'd0;
        fork
            monitor();
            ready_gen();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_frame_done", frame_done, 0);
        tick();
        rst = 1'b0;

        // Two ports contending from reset: 0, 1, 0.
        d0 = n_done; t0 = n_trunc;
        q_owner.push_back(0); q_owner.push_back(1); q_owner.push_back(0);
        fork
            begin
                send_frame(0, 4, 8'h10, 0);
                send_frame(0, 4, 8'h20, 0);
            end
            send_frame(1, 4, 8'h80, 0);
        join
        check_end("t1", d0, 3, t0, 0);

        // Ten back-to-back MAX-length frames with natural tlast on the last allowed beat.
        d0 = n_done; t0 = n_trunc; mb0 = mbeats;
        ts = $time;
        for (int f = 0; f < 10; f++) send_frame(0, MFL, 8'(f * 16), 0);
        te = $time;
        chk("t2_cycles", 32'((te - ts) / 10), 10 * (MFL + 1));
        chk("t2_beats", mbeats - mb0, 10 * MFL);
        check_end("t2", d0, 10, t0, 0);

        // 20-beat frame truncated to 16, remaining 4 drained without stall.
        d0 = n_done; t0 = n_trunc; mb0 = mbeats;
        ts = $time;
        send_frame(1, 20, 8'hA0, 0);
        te = $time;
        chk("t3_cycles", 32'((te - ts) / 10), 21);
        chk("t3_beats", mbeats - mb0, MFL);
        check_end("t3", d0, 1, t0, 1);

        // FIFO hold-off before a frame, ignored inside one.
        d0 = n_done; t0 = n_trunc;
        status = 4'd12;
        fork
            send_frame(0, 6, 8'h40, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("t4_hold_grant", grant, 0);
                    chk("t4_hold_busy", busy, 0);
                end
                tick();
                status = 4'd11;
                @(posedge clk);
                @(negedge clk);
                chk("t4_grant_after_release", grant, 2'b01);
                tick();
                status = 4'd15;
            end
        join
        status = 4'd0;
        check_end("t4", d0, 1, t0, 0);

        // Random backpressure and source gaps on both ports.
        d0 = n_done; t0 = n_trunc;
        rdy_rand = 1'b1;
        fork
            begin
                send_frame(0, 3, 8'h01, 40);
                send_frame(0, 7, 8'h11, 40);
                send_frame(0, 1, 8'h21, 40);
                send_frame(0, 16, 8'h31, 40);
                send_frame(0, 5, 8'h51, 40);
            end
            begin
                send_frame(1, 18, 8'h61, 40);
                send_frame(1, 2, 8'h81, 40);
                send_frame(1, 9, 8'h91, 40);
                send_frame(1, 17, 8'hB1, 40);
            end
        join
        rdy_rand = 1'b0;
        check_end("t5", d0, 9, t0, 2);

        // Reset mid-frame, then port 0 must win first again.
        mb0 = mbeats;
        fork
            send_frame(0, 10, 8'h50, 0);
            begin
                reached = 1'b0;
                for (int c = 0; c < 300 && !reached; c++) begin
                    @(negedge clk);
                    #1;
                    reached = (mbeats >= mb0 + 5);
                end
                if (!reached) begin
                    n_total++;
                    $display("FAIL t6_reach_beat5: got %0d beats, required 5", mbeats - mb0);
                end
                rst = 1'b1;
                abort = 1'b1;
                #1;
                chk("t6_rst_grant", grant, 0);
                chk("t6_rst_busy", busy, 0);
                chk("t6_rst_m_tvalid", m_tvalid, 0);
                chk("t6_rst_m_tlast", m_tlast, 0);
                chk("t6_rst_m_tdata", m_tdata, 0);
                chk("t6_rst_s_tready", s_tready, 0);
            end
        join
        q0.delete();
        q1.delete();
        q_owner.delete();
        repeat (2) tick();
        rst = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_post_grant", grant, 0);
        d0 = n_done; t0 = n_trunc;
        q_owner.push_back(0); q_owner.push_back(1);
        fork
            send_frame(1, 3, 8'hC0, 0);
            send_frame(0, 3, 8'hD0, 0);
        join
        check_end("t6", d0, 2, t0, 0);
        chk("t6_owner_q_left", q_owner.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
